fft_agu_n: RTL

FFT_AGU_N -- requirements
Module: fft_agu_n

---
 rtl/fft_agu_n.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fft_agu_n.sv
// Address generator for an in-place radix-2 DIT FFT that ping-pongs between two memories.
// Issues butterfly read addresses and replays them as write addresses LATENCY cycles later.
module fft_agu_n #(
  parameter int unsigned N_POINTS = 8,
  parameter int unsigned LATENCY  = 2,
  localparam int unsigned STAGES  = $clog2(N_POINTS),
  localparam int unsigned AW      = STAGES
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          fft_done,
  output logic          read_mem_sel,
  output logic          result_mem_sel,
  output logic          rd_valid,
  output logic          mem_1_wr,
  output logic          mem_2_wr,
  output logic [AW-2:0] twiddle_addr,
  output logic [AW-1:0] addr_1_a,
  output logic [AW-1:0] addr_1_b,
  output logic [AW-1:0] addr_2_a,
  output logic [AW-1:0] addr_2_b
);

  localparam int unsigned KW = AW - 1;
  localparam int unsigned SW = $clog2(STAGES);
  localparam int unsigned CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Write-replay pipeline; entry 0 mirrors the read currently on the outputs.
  logic [LATENCY-1:0] pv_q, pm_q;
  logic [AW-1:0]      pa_q [LATENCY];
  logic [AW-1:0]      pb_q [LATENCY];

  logic          busy_q, done_q, rsel_q, rdv_q, wr1_q, wr2_q;
  logic [AW-2:0] tw_q;
  logic [AW-1:0] a1a_q, a1b_q, a2a_q, a2b_q;

  logic          rd_d, rsel_d, wr1_d, wr2_d;
  logic [AW-1:0] kx, span, mask, pos, a_d, b_d, tw_full;
  logic [AW-2:0] tw_d;
  logic [AW-1:0] a1a_d, a1b_d, a2a_d, a2b_d;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (k_q == KW'(N_POINTS / 2 - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CW'(LATENCY - 1)) begin
          if (stage_q == SW'(STAGES - 1)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Butterfly addresses for the cycle being entered: a inserts a 0 at bit `stage` of k.
  always_comb begin
    kx      = {1'b0, k_d};
    span    = AW'(1) << stage_d;
    mask    = span - 1'b1;
    pos     = kx & mask;
    a_d     = ((kx & ~mask) << 1) | pos;
    b_d     = a_d + span;
    tw_full = pos << (SW'(STAGES - 1) - stage_d);
    rd_d    = (state_d == StRun);
    rsel_d  = stage_d[0];
    tw_d    = rd_d ? tw_full[AW-2:0] : '0;
  end

  always_comb begin
    wr1_d = pv_q[LATENCY-1] & ~pm_q[LATENCY-1];
    wr2_d = pv_q[LATENCY-1] & pm_q[LATENCY-1];
    a1a_d = a1a_q;
    a1b_d = a1b_q;
    a2a_d = a2a_q;
    a2b_d = a2b_q;
    if (rd_d && !rsel_d) begin
      a1a_d = a_d;
      a1b_d = b_d;
    end else if (wr1_d) begin
      a1a_d = pa_q[LATENCY-1];
      a1b_d = pb_q[LATENCY-1];
    end
    if (rd_d && rsel_d) begin
      a2a_d = a_d;
      a2b_d = b_d;
    end else if (wr2_d) begin
      a2a_d = pa_q[LATENCY-1];
      a2b_d = pb_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      pv_q    <= '0;
      pm_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rsel_q  <= 1'b0;
      rdv_q   <= 1'b0;
      wr1_q   <= 1'b0;
      wr2_q   <= 1'b0;
      tw_q    <= '0;
      a1a_q   <= '0;
      a1b_q   <= '0;
      a2a_q   <= '0;
      a2b_q   <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      pv_q[0] <= rd_d;
      pm_q[0] <= ~rsel_d;
      pa_q[0] <= a_d;
      pb_q[0] <= b_d;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pm_q[i] <= pm_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
      busy_q  <= (state_d == StRun) || (state_d == StDrain);
      done_q  <= (state_d == StDone);
      rsel_q  <= rsel_d;
      rdv_q   <= rd_d;
      wr1_q   <= wr1_d;
      wr2_q   <= wr2_d;
      tw_q    <= tw_d;
      a1a_q   <= a1a_d;
      a1b_q   <= a1b_d;
      a2a_q   <= a2a_d;
      a2b_q   <= a2b_d;
    end
  end

  assign busy           = busy_q;
  assign fft_done       = done_q;
  assign read_mem_sel   = rsel_q;
  assign result_mem_sel = 1'(STAGES % 2);
  assign rd_valid       = rdv_q;
  assign mem_1_wr       = wr1_q;
  assign mem_2_wr       = wr2_q;
  assign twiddle_addr   = tw_q;
  assign addr_1_a       = a1a_q;
  assign addr_1_b       = a1b_q;
  assign addr_2_a       = a2a_q;
  assign addr_2_b       = a2b_q;

endmodule
